// File: rtl/seq_pkg.sv
// Shared sizing and state encoding for the beat-driven pattern scheduler.
package seq_pkg;
    localparam int STEPS  = 16;
    localparam int TONES  = 12;
    localparam int LOOP_W = 7;
    localparam int STEP_W = $clog2(STEPS);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_e;
endpackage

// File: rtl/step_pattern_mem.sv
// Flop-based STEPS x TONES pattern store with a combinational read and
// write-through bypass, so a step being entered sees same-cycle writes.
module step_pattern_mem #(
    parameter int STEPS = 16,
    parameter int TONES = 12,
    parameter int IDX_W = $clog2(STEPS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_step_i,
    input  logic [TONES-1:0] wr_data_i,
    input  logic [IDX_W-1:0] rd_step_i,
    output logic [TONES-1:0] rd_data_o
);
    logic [TONES-1:0] pat_q [STEPS];

    // Each row needs a synchronous clear, so the store is kept in flops.
    generate
        for (genvar gi = 0; gi < STEPS; gi++) begin : g_row
            always_ff @(posedge clk) begin
                if (reset) begin
                    pat_q[gi] <= '0;
                end else if (wr_en_i && (wr_step_i == IDX_W'(gi))) begin
                    pat_q[gi] <= wr_data_i;
                end
            end
        end
    endgenerate

    always_comb begin
        rd_data_o = pat_q[rd_step_i];
        if (wr_en_i && (wr_step_i == rd_step_i)) begin
            rd_data_o = wr_data_i;
        end
    end
endmodule

// File: rtl/step_scheduler.sv
// Steps through a stored tone pattern on each beat, driving the tone select
// mask and a retrigger pulse, and ends playback after a programmed loop count.
module step_scheduler
    import seq_pkg::*;
#(
    parameter int STEPS  = seq_pkg::STEPS,
    parameter int TONES  = seq_pkg::TONES,
    parameter int LOOP_W = seq_pkg::LOOP_W
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      bpm_step,
    input  logic [LOOP_W-1:0]         Loops,
    input  logic                      wr_en,
    input  logic [$clog2(STEPS)-1:0]  wr_step,
    input  logic [TONES-1:0]          wr_data,
    output logic [TONES-1:0]          Select,
    output logic                      tone_trig,
    output logic [$clog2(STEPS)-1:0]  step_idx,
    output logic [LOOP_W-1:0]         loop_cnt,
    output logic                      play_en,
    output logic                      done
);
    localparam int IDX_W = $clog2(STEPS);
    localparam logic [IDX_W-1:0] LAST_STEP = IDX_W'(STEPS - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  step_q, step_d;
    logic [LOOP_W-1:0] loop_q, loop_d;
    logic [LOOP_W-1:0] loops_q, loops_d;
    logic [TONES-1:0]  sel_q, sel_d;
    logic              trig_q, trig_d;
    logic              play_q, play_d;
    logic              done_q, done_d;

    logic [IDX_W-1:0]  enter_step;
    logic [TONES-1:0]  enter_data;
    logic [LOOP_W-1:0] loop_inc;

    // STEPS is a power of two, so step_q + 1 wraps to step 0 after the last step.
    assign enter_step = start ? '0 : (step_q + 1'b1);
    assign loop_inc   = loop_q + 1'b1;

    step_pattern_mem #(
        .STEPS (STEPS),
        .TONES (TONES),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk       (CLOCK_50),
        .reset     (reset),
        .wr_en_i   (wr_en),
        .wr_step_i (wr_step),
        .wr_data_i (wr_data),
        .rd_step_i (enter_step),
        .rd_data_o (enter_data)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            loop_q  <= '0;
            loops_q <= '0;
            sel_q   <= '0;
            trig_q  <= 1'b0;
            play_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            loop_q  <= loop_d;
            loops_q <= loops_d;
            sel_q   <= sel_d;
            trig_q  <= trig_d;
            play_q  <= play_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        loop_d  = loop_q;
        loops_d = loops_q;
        sel_d   = sel_q;
        trig_d  = 1'b0;
        play_d  = play_q;
        done_d  = 1'b0;

        if (stop) begin
            state_d = S_IDLE;
            step_d  = '0;
            sel_d   = '0;
            play_d  = 1'b0;
        end else if (start) begin
            state_d = S_PLAY;
            step_d  = '0;
            loop_d  = '0;
            loops_d = Loops;
            sel_d   = enter_data;
            trig_d  = |enter_data;
            play_d  = 1'b1;
        end else if ((state_q == S_PLAY) && bpm_step) begin
            if (step_q != LAST_STEP) begin
                step_d = enter_step;
                sel_d  = enter_data;
                trig_d = |enter_data;
            end else if ((loops_q != '0) && (loop_inc == loops_q)) begin
                // Final pass: loop_cnt keeps its last completed value.
                state_d = S_IDLE;
                step_d  = '0;
                sel_d   = '0;
                play_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                step_d = '0;
                loop_d = loop_inc;
                sel_d  = enter_data;
                trig_d = |enter_data;
            end
        end
    end

    assign Select    = sel_q;
    assign tone_trig = trig_q;
    assign step_idx  = step_q;
    assign loop_cnt  = loop_q;
    assign play_en   = play_q;
    assign done      = done_q;
endmodule

// File: tb/tb_step_scheduler.sv
// Directed bench for step_scheduler: a cycle-level behavioural model is
// compared on every falling edge, plus literal checkpoints.
module tb_step_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, stop = 1'b0, bpm_step = 1'b0, wr_en = 1'b0;
    logic [6:0]  Loops = '0;
    logic [3:0]  wr_step = '0;
    logic [11:0] wr_data = '0;
    logic [11:0] Select;
    logic        tone_trig, play_en, done;
    logic [3:0]  step_idx;
    logic [6:0]  loop_cnt;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    step_scheduler dut (
        .CLOCK_50 (clk),      .reset    (reset),
        .start    (start),    .stop     (stop),
        .bpm_step (bpm_step), .Loops    (Loops),
        .wr_en    (wr_en),    .wr_step  (wr_step),
        .wr_data  (wr_data),  .Select   (Select),
        .tone_trig(tone_trig),.step_idx (step_idx),
        .loop_cnt (loop_cnt), .play_en  (play_en),
        .done     (done)
    );

    // Behavioural model: playing flag, position, completed passes, latched mask.
    logic [11:0] m_pat [16];
    bit          m_play = 0, m_trig = 0, m_done = 0;
    int          m_step = 0, m_loop = 0, m_loops = 0;
    logic [11:0] m_sel = '0;

    initial for (int i = 0; i < 16; i++) m_pat[i] = '0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) m_pat[i] = '0;
            m_play = 0; m_trig = 0; m_done = 0;
            m_step = 0; m_loop = 0; m_sel = '0;
        end else begin
            m_trig = 0;
            m_done = 0;
            // A write lands this cycle and is seen by any step entered now.
            if (wr_en) m_pat[wr_step] = wr_data;
            if (stop) begin
                m_play = 0; m_step = 0; m_sel = '0;
            end else if (start) begin
                m_play = 1; m_loops = int'(Loops); m_loop = 0; m_step = 0;
                m_sel = m_pat[0]; m_trig = (m_pat[0] != 0);
            end else if (bpm_step && m_play) begin
                if (m_step == 15 && m_loops != 0 && m_loop + 1 == m_loops) begin
                    m_play = 0; m_step = 0; m_sel = '0; m_done = 1;
                end else begin
                    if (m_step == 15) m_loop = (m_loop + 1) % 128;
                    m_step = (m_step + 1) % 16;
                    m_sel  = m_pat[m_step];
                    m_trig = (m_sel != 0);
                end
            end
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model_select", int'(Select), int'(m_sel));
            cmp("model_trig", int'(tone_trig), int'(m_trig));
            cmp("model_step", int'(step_idx), m_step);
            cmp("model_loop", int'(loop_cnt), m_loop);
            cmp("model_play", int'(play_en), int'(m_play));
            cmp("model_done", int'(done), int'(m_done));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        start = 0; stop = 0; bpm_step = 0; wr_en = 0; reset = 0;
    endtask

    task automatic write(input int s, input int d);
        wr_en = 1; wr_step = 4'(s); wr_data = 12'(d);
        tick();
    endtask

    task automatic do_start(input int loops);
        start = 1; Loops = 7'(loops);
        tick();
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) begin
            bpm_step = 1;
            tick();
        end
    endtask

    initial begin
        tick();
        chk_en = 1'b1;
        $display("reset: Select=%0h play_en=%0b", Select, play_en);
        cmp("rst_select", int'(Select), 0);
        cmp("rst_step", int'(step_idx), 0);
        cmp("rst_play", int'(play_en), 0);

        // Basic stepping with Loops=1
        write(0, 12'h001); write(1, 12'h000); write(2, 12'h800);
        do_start(1);
        $display("start L=1: Select=%0h trig=%0b", Select, tone_trig);
        cmp("s0_select", int'(Select), 12'h001);
        cmp("s0_trig", int'(tone_trig), 1);
        beats(1);
        $display("step1: Select=%0h trig=%0b", Select, tone_trig);
        cmp("s1_select", int'(Select), 12'h000);
        cmp("s1_trig", int'(tone_trig), 0);
        beats(1);
        $display("step2: Select=%0h trig=%0b", Select, tone_trig);
        cmp("s2_select", int'(Select), 12'h800);
        cmp("s2_trig", int'(tone_trig), 1);
        beats(14);
        $display("end L=1: done=%0b play_en=%0b", done, play_en);
        cmp("l1_done", int'(done), 1);
        cmp("l1_play", int'(play_en), 0);

        // Two passes
        tick();
        do_start(2);
        beats(16);
        $display("L=2 pass1: loop_cnt=%0d step=%0d", loop_cnt, step_idx);
        cmp("l2_loop1", int'(loop_cnt), 1);
        beats(16);
        $display("L=2 end: done=%0b play=%0b sel=%0h loop=%0d", done, play_en, Select, loop_cnt);
        cmp("l2_done", int'(done), 1);
        cmp("l2_play", int'(play_en), 0);
        cmp("l2_select", int'(Select), 0);
        cmp("l2_loop", int'(loop_cnt), 1);
        tick();
        cmp("l2_done_width", int'(done), 0);

        // Same-cycle priorities
        start = 1; stop = 1; Loops = 7'd0;
        tick();
        $display("start+stop idle: play_en=%0b", play_en);
        cmp("ss_idle_play", int'(play_en), 0);
        do_start(0);
        beats(3);
        stop = 1; bpm_step = 1;
        tick();
        $display("stop+bpm: play_en=%0b step=%0d", play_en, step_idx);
        cmp("sb_play", int'(play_en), 0);
        cmp("sb_step", int'(step_idx), 0);
        do_start(0);
        beats(5);
        start = 1; bpm_step = 1; Loops = 7'd0;
        tick();
        $display("start+bpm play: step=%0d", step_idx);
        cmp("stb_step", int'(step_idx), 0);

        // Write bypass on entry, then a write to the current step
        beats(2);
        bpm_step = 1; wr_en = 1; wr_step = 4'd3; wr_data = 12'h0F0;
        tick();
        $display("bypass: step=%0d Select=%0h trig=%0b", step_idx, Select, tone_trig);
        cmp("byp_select", int'(Select), 12'h0F0);
        cmp("byp_trig", int'(tone_trig), 1);
        write(3, 12'h0AA);
        $display("write current: Select=%0h", Select);
        cmp("wcur_select", int'(Select), 12'h0F0);
        beats(13);
        stop = 1;
        tick();

        // Infinite mode, 200 passes
        do_start(0);
        for (int p = 1; p <= 200; p++) begin
            beats(16);
            if (p == 127) cmp("inf_loop127", int'(loop_cnt), 127);
            if (p == 128) cmp("inf_wrap", int'(loop_cnt), 0);
        end
        $display("infinite 200: loop_cnt=%0d play_en=%0b", loop_cnt, play_en);
        cmp("inf_play", int'(play_en), 1);
        cmp("inf_loop200", int'(loop_cnt), 200 % 128);
        stop = 1;
        tick();

        // Reset in the middle of playback
        do_start(0);
        beats(55);
        $display("pre-reset: step=%0d loop=%0d", step_idx, loop_cnt);
        cmp("pre_rst_step", int'(step_idx), 7);
        cmp("pre_rst_loop", int'(loop_cnt), 3);
        reset = 1;
        tick();
        $display("mid reset: Select=%0h step=%0d loop=%0d play=%0b", Select, step_idx, loop_cnt, play_en);
        cmp("mrst_select", int'(Select), 0);
        cmp("mrst_step", int'(step_idx), 0);
        cmp("mrst_loop", int'(loop_cnt), 0);
        cmp("mrst_play", int'(play_en), 0);
        do_start(0);
        cmp("mrst_pat0", int'(Select), 0);
        cmp("mrst_trig0", int'(tone_trig), 0);
        beats(3);
        cmp("mrst_pat3", int'(Select), 0);
        beats(13);
        stop = 1;
        tick();
        tick();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/step_scheduler.md
# step_scheduler

Pattern scheduler that sequences the tone generators once per beat. It holds a 16-step × 12-tone pattern and advances through it on each `bpm_step` pulse from the BPM counter. It drives `Select` and a retrigger pulse into the audio generators, and counts pattern loops to end playback. It sits between the user/pattern-entry logic and `audio_interface`, and replaces the free-running start/loop behaviour with per-step tone selection.

## Interface
Parameters:
- `STEPS`, 16: pattern length; power of two.
- `TONES`, 12: tone bits per step.
- `LOOP_W`, 7: loop counter width.

Ports:
- `CLOCK_50`  in  1  system clock.
- `reset`  in  1  reset; one clock; reset is synchronous and active-high.
- `start`  in  1  1-cycle pulse; begin or restart playback at step 0.
- `stop`  in  1  1-cycle pulse; abort playback.
- `bpm_step`  in  1  1-cycle beat pulse from the BPM counter.
- `Loops`  in  LOOP_W  number of pattern passes; 0 = infinite; sampled on `start`.
- `wr_en`  in  1  pattern write strobe.
- `wr_step`  in  log2(STEPS)  step address to write.
- `wr_data`  in  TONES  tone mask for that step.
- `Select`  out  TONES  tone mask of the current step; 0 when not playing.
- `tone_trig`  out  1  1-cycle pulse on step entry when the step mask is nonzero.
- `step_idx`  out  log2(STEPS)  current step.
- `loop_cnt`  out  LOOP_W  completed passes.
- `play_en`  out  1  high while playing.
- `done`  out  1  1-cycle pulse when the final pass completes.

## Operation
- Pattern store: STEPS×TONES flops. `wr_en` writes `pattern[wr_step] <= wr_data` in any state. Writes are never blocked.
- FSM states are IDLE and PLAY.
- IDLE → PLAY on `start` (and not `stop`):
  - `step_idx` ← 0, `loop_cnt` ← 0, `Loops` latched into `loops_q`.
  - `Select` ← pattern[0], `tone_trig` ← (pattern[0] != 0).
- PLAY, on `bpm_step`:
  - If `step_idx` < STEPS-1: increment `step_idx` and load `Select`/`tone_trig` from the new step.
  - If `step_idx` == STEPS-1:
    - If `loops_q` != 0 and `loop_cnt`+1 == `loops_q`: go to IDLE, `done` ← 1, `play_en` ← 0, `Select` ← 0, `step_idx` ← 0. `loop_cnt` holds its final value until the next `start`.
    - Otherwise `step_idx` ← 0 and `loop_cnt` ← `loop_cnt`+1. In infinite mode the count wraps modulo 2^LOOP_W.
- PLAY → IDLE on `stop`: `Select` ← 0, `play_en` ← 0, `step_idx` ← 0, and no `done` pulse.
- `start` in PLAY restarts exactly as from IDLE, and re-samples `Loops`.
- Priority order is `stop` > `start` > `bpm_step`. A `bpm_step` in the same cycle as `start` is ignored.
- `Select` is latched on step entry. A later write to the current step is not visible until that step is re-entered.
- Write bypass: if `wr_en` targets the step being entered in the same cycle, `wr_data` is used for `Select`/`tone_trig`.
- `bpm_step` in IDLE is ignored.

## Timing
- All outputs are registered.
- Reset values: `Select`=0, `tone_trig`=0, `step_idx`=0, `loop_cnt`=0, `play_en`=0, `done`=0, state IDLE. The pattern clears to 0.
- Reset mid-PLAY takes effect on the next edge, identically to the reset values above.
- Latency: `start` or `bpm_step` at edge t gives new `step_idx`/`Select`/`tone_trig` visible after edge t (one cycle).
- `play_en` rises one cycle after `start` and falls one cycle after `stop` or the final step boundary. It falls in the same cycle `done` pulses.
- `tone_trig` and `done` are exactly 1 cycle wide. They never overlap.

## Structure
- Package `seq_pkg`: `STEPS`, `TONES`, `LOOP_W`, derived `STEP_W` = $clog2(STEPS), and the state enum {`S_IDLE`, `S_PLAY`}.
- Sub-module `step_pattern_mem`:
  - Write port: `wr_en`/`wr_step`/`wr_data`.
  - Combinational read port with write bypass.
  - Clears on `reset`.
- FSM, step counter and loop counter live in `step_scheduler`.

## Test plan
- Write pattern[0]=12'h001, pattern[1]=12'h000, pattern[2]=12'h800; `start` with `Loops`=1:
  - Step 0: `Select`=001, `tone_trig` pulses.
  - Step 1 (after `bpm_step`): `Select`=000, no trig.
  - Step 2: `Select`=800, trig.
- `Loops`=2 with 16 `bpm_step` pulses per pass:
  - `loop_cnt` reaches 1 after pass 1.
  - After the 32nd pulse: `done` is a 1-cycle pulse, `play_en`=0, `Select`=0, `loop_cnt`=1.
- `Loops`=0, 200 passes: never `done`; `loop_cnt` wraps 127→0; `play_en` stays 1.
- Same-cycle cases:
  - `start`+`stop` in IDLE: stays IDLE.
  - `stop`+`bpm_step` in PLAY: IDLE, `step_idx`=0.
  - `start`+`bpm_step` in PLAY: `step_idx`=0.
- Write bypass:
  - `wr_en` to step 3 with data 12'h0F0 in the same cycle as the `bpm_step` entering step 3: `Select`=0F0.
  - Write to step 3 while at step 3: `Select` unchanged.
- Assert `reset` mid-PLAY at step 7, `loop_cnt`=3: next cycle all outputs are 0 and the pattern reads back 0.
